// File: rtl/param.sv
// Width constants shared by the ATM cash transaction engine, its bus interface and its bench.
package param;
   localparam int CREDIT_VAL_SIZE = 25;
   localparam int UP_LIMIT_SIZE   = 15;
   localparam int ATM_CAP_SIZE    = 18;
   localparam int PINCARD_SIZE    = 6;
   localparam int WITHDRAW_SIZE   = 15;
   localparam int RAM_DATA_WIDTH  = 40;
endpackage

// File: rtl/atm_cash_txn_if.sv
// Request/response and account-RAM signals of the ATM cash transaction engine.
// Handshake: the host pulses start for one cycle while busy=0 and the request (op, card_idx,
// amount) is taken on that clock edge; a start seen while busy=1 is dropped, never queued.
// Completion is a one-cycle done pulse with status and new_balance valid in that cycle.
// The RAM returns ram_rdata one cycle after ram_rd_en; a write lands on the edge that ends
// the ram_wr_en cycle. dbg_state mirrors the engine's FSM state for observation.
interface atm_cash_txn_if;
   import param::*;

   logic                        start;
   logic                        op;
   logic [PINCARD_SIZE-1:0]     card_idx;
   logic [WITHDRAW_SIZE-1:0]    amount;
   logic                        ram_rd_en;
   logic [PINCARD_SIZE-1:0]     ram_addr;
   logic [RAM_DATA_WIDTH-1:0]   ram_rdata;
   logic                        ram_wr_en;
   logic [RAM_DATA_WIDTH-1:0]   ram_wdata;
   logic                        busy;
   logic                        done;
   logic [2:0]                  status;
   logic [CREDIT_VAL_SIZE-1:0]  new_balance;
   logic [ATM_CAP_SIZE-1:0]     atm_cash;
   logic [2:0]                  dbg_state;

   modport master (
      output start, op, card_idx, amount, ram_rdata,
      input  ram_rd_en, ram_addr, ram_wr_en, ram_wdata, busy, done, status,
             new_balance, atm_cash, dbg_state
   );

   modport slave (
      input  start, op, card_idx, amount, ram_rdata,
      output ram_rd_en, ram_addr, ram_wr_en, ram_wdata, busy, done, status,
             new_balance, atm_cash, dbg_state
   );
endinterface

// File: rtl/atm_cash_txn.sv
// ATM cash transaction engine: reads an account record, validates a deposit or withdrawal
// against the account limit, balance and machine cash, then writes back and reports status.
module atm_cash_txn
   import param::*;
#(
   parameter logic [ATM_CAP_SIZE-1:0] ATM_INIT_CASH = 18'd100000
) (
   input  logic          clk,
   input  logic          rst,
   atm_cash_txn_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CHK  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] ST_OK         = 3'd0;
   localparam logic [2:0] ST_ZERO_AMT   = 3'd1;
   localparam logic [2:0] ST_OVER_LIMIT = 3'd2;
   localparam logic [2:0] ST_INSUFF_BAL = 3'd3;
   localparam logic [2:0] ST_ATM_EMPTY  = 3'd4;
   localparam logic [2:0] ST_BAL_OVF    = 3'd5;
   localparam logic [2:0] ST_ATM_FULL   = 3'd6;

   // All checks run one bit wider than the widest operand (the 25-bit credit) so sums never wrap.
   localparam int           CW         = CREDIT_VAL_SIZE + 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'({CREDIT_VAL_SIZE{1'b1}});
   localparam logic [CW-1:0] CASH_MAX   = CW'({ATM_CAP_SIZE{1'b1}});

   state_t                      state_q;
   logic                        op_q;
   logic [PINCARD_SIZE-1:0]     idx_q;
   logic [WITHDRAW_SIZE-1:0]    amt_q;
   logic                        rd_en_q;
   logic                        wr_en_q;
   logic [PINCARD_SIZE-1:0]     addr_q;
   logic [RAM_DATA_WIDTH-1:0]   wdata_q;
   logic                        busy_q;
   logic                        done_q;
   logic [2:0]                  status_q;
   logic [CREDIT_VAL_SIZE-1:0]  bal_q;
   logic [ATM_CAP_SIZE-1:0]     cash_q;

   logic [UP_LIMIT_SIZE-1:0]    rd_lim;
   logic [CREDIT_VAL_SIZE-1:0]  rd_credit;
   logic [CW-1:0]               amt_w;
   logic [CW-1:0]               lim_w;
   logic [CW-1:0]               credit_w;
   logic [CW-1:0]               cash_w;
   logic [2:0]                  status_d;
   logic [CREDIT_VAL_SIZE-1:0]  credit_d;
   logic [ATM_CAP_SIZE-1:0]     cash_d;

   // Decision for the record on ram_rdata: first failing rule wins, otherwise apply the transaction.
   always_comb begin
      rd_lim    = bus.ram_rdata[RAM_DATA_WIDTH-1:CREDIT_VAL_SIZE];
      rd_credit = bus.ram_rdata[CREDIT_VAL_SIZE-1:0];
      amt_w     = CW'(amt_q);
      lim_w     = CW'(rd_lim);
      credit_w  = CW'(rd_credit);
      cash_w    = CW'(cash_q);
      status_d  = ST_OK;
      credit_d  = rd_credit;
      cash_d    = cash_q;
      if (amt_w == '0) begin
         status_d = ST_ZERO_AMT;
      end else if (op_q && (amt_w > lim_w)) begin
         status_d = ST_OVER_LIMIT;
      end else if (op_q && (amt_w > credit_w)) begin
         status_d = ST_INSUFF_BAL;
      end else if (op_q && (amt_w > cash_w)) begin
         status_d = ST_ATM_EMPTY;
      end else if (!op_q && ((credit_w + amt_w) > CREDIT_MAX)) begin
         status_d = ST_BAL_OVF;
      end else if (!op_q && ((cash_w + amt_w) > CASH_MAX)) begin
         status_d = ST_ATM_FULL;
      end else if (op_q) begin
         credit_d = CREDIT_VAL_SIZE'(credit_w - amt_w);
         cash_d   = ATM_CAP_SIZE'(cash_w - amt_w);
      end else begin
         credit_d = CREDIT_VAL_SIZE'(credit_w + amt_w);
         cash_d   = ATM_CAP_SIZE'(cash_w + amt_w);
      end
   end

   // Transaction FSM with every output registered; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         idx_q    <= '0;
         amt_q    <= '0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         status_q <= ST_OK;
         bal_q    <= '0;
         cash_q   <= ATM_INIT_CASH;
      end else begin
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  op_q    <= bus.op;
                  idx_q   <= bus.card_idx;
                  amt_q   <= bus.amount;
                  rd_en_q <= 1'b1;
                  addr_q  <= bus.card_idx;
                  busy_q  <= 1'b1;
                  state_q <= S_RD;
               end
            end
            S_RD: begin
               state_q <= S_CHK;
            end
            S_CHK: begin
               status_q <= status_d;
               bal_q    <= credit_d;
               if (status_d == ST_OK) begin
                  wr_en_q <= 1'b1;
                  addr_q  <= idx_q;
                  wdata_q <= {rd_lim, credit_d};
                  cash_q  <= cash_d;
                  state_q <= S_WR;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_WR: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ram_rd_en   = rd_en_q;
   assign bus.ram_wr_en   = wr_en_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_wdata   = wdata_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.status      = status_q;
   assign bus.new_balance = bal_q;
   assign bus.atm_cash    = cash_q;
   assign bus.dbg_state   = state_q;

endmodule
